// File: rtl/mips_pkg.sv
// Shared constants for the MIPS core front end:
// opcode values, fetch FSM encoding and PC step.
package mips_pkg;

  localparam logic [5:0] ALU_R      = 6'h00;
  localparam logic [5:0] JUMP       = 6'h02;
  localparam logic [5:0] BRANCH_EQ  = 6'h04;
  localparam logic [5:0] ADDI       = 6'h08;
  localparam logic [5:0] LOAD_WORD  = 6'h23;
  localparam logic [5:0] STORE_WORD = 6'h2B;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    VALID = 2'd2
  } fetch_state_t;

  localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: instruction memory req/gnt/rvalid side
// plus the valid/ready hand-off towards decode.
interface instr_fetch_unit_if #(
  parameter int unsigned ADDR_W = 32
);

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [31:0]       imem_rdata;

  logic              instr_valid;
  logic [31:0]       instr;
  logic [5:0]        opcode;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_ready;
  logic              jump;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata,
    output instr_valid,
    output instr,
    output opcode,
    output instr_pc,
    input  instr_ready,
    input  jump
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata,
    input  instr_valid,
    input  instr,
    input  opcode,
    input  instr_pc,
    output instr_ready,
    output jump
  );

endinterface

// File: rtl/fetch_pc_next.sv
// Combinational next-PC select: branch redirect,
// then jump target, else sequential pc4.
module fetch_pc_next
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              jump,
  input  logic [25:0]       jump_index,
  input  logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] next_pc
);

  logic [ADDR_W-1:0] pc4;
  logic [ADDR_W-1:0] jump_pc;
  logic [ADDR_W-1:0] branch_pc;

  assign pc4       = instr_pc + ADDR_W'(PC_INC);
  assign jump_pc   = {pc4[ADDR_W-1:28], jump_index, 2'b00};
  // Word-align the branch target; low bits are don't-care.
  assign branch_pc = redirect_pc & ~ADDR_W'(3);

  always_comb begin
    next_pc = pc4;
    unique case (1'b1)
      redirect_valid:            next_pc = branch_pc;
      (!redirect_valid && jump): next_pc = jump_pc;
      default:                   next_pc = pc4;
    endcase
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, one outstanding
// imem read, single-entry buffer towards decode.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  instr_fetch_unit_if.master  io,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_pc
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] instr_pc_q;
  logic [ADDR_W-1:0] next_pc;
  logic [31:0]       instr_q;
  logic              squash;
  logic              req_q;
  logic              valid_q;
  logic              handshake;
  logic              pc_load;

  assign handshake = valid_q && io.instr_ready;
  assign pc_load   = redirect_valid || handshake;

  assign io.imem_req    = req_q;
  assign io.imem_addr   = pc;
  assign io.instr_valid = valid_q;
  assign io.instr       = instr_q;
  assign io.opcode      = instr_q[31:26];
  assign io.instr_pc    = instr_pc_q;

  fetch_pc_next #(
    .ADDR_W(ADDR_W)
  ) u_pc_next (
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .jump          (io.jump && valid_q),
    .jump_index    (instr_q[25:0]),
    .instr_pc      (instr_pc_q),
    .next_pc       (next_pc)
  );

  // req_q/valid_q mirror FETCH/VALID but stay low in reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      squash     <= 1'b0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      if (pc_load) begin
        pc <= next_pc;
      end
      unique case (state)
        FETCH: begin
          if (req_q && io.imem_gnt) begin
            state  <= WAIT;
            req_q  <= 1'b0;
            squash <= redirect_valid;
          end else begin
            req_q <= 1'b1;
          end
        end
        WAIT: begin
          if (io.imem_rvalid) begin
            if (squash || redirect_valid) begin
              state  <= FETCH;
              squash <= 1'b0;
              req_q  <= 1'b1;
            end else begin
              state      <= VALID;
              valid_q    <= 1'b1;
              instr_q    <= io.imem_rdata;
              instr_pc_q <= pc;
            end
          end else if (redirect_valid) begin
            squash <= 1'b1;
          end
        end
        VALID: begin
          if (redirect_valid || io.instr_ready) begin
            state   <= FETCH;
            valid_q <= 1'b0;
            req_q   <= 1'b1;
          end
        end
        default: begin
          state   <= FETCH;
          squash  <= 1'b0;
          valid_q <= 1'b0;
          req_q   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a small
// imem model of programmable read latency.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        gnt_en;
  int          rv_lat;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int t_req;
  int t_val;

  logic        pend;
  int          cnt;
  logic [31:0] pend_addr;
  logic [31:0] gnt_addr;

  instr_fetch_unit_if #(.ADDR_W(32)) bus ();

  instr_fetch_unit #(
    .ADDR_W  (32),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .io            (bus),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0040) return 32'h0800_0010;
    return a ^ 32'hAC00_0000;
  endfunction

  // Memory model: grant while enabled, answer rv_lat cycles later.
  always @(negedge clk) begin
    if (rst) begin
      pend            = 1'b0;
      cnt             = 0;
      pend_addr       = '0;
      gnt_addr        = '0;
      bus.imem_gnt    = 1'b0;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = '0;
    end else begin
      bus.imem_rvalid = 1'b0;
      if (bus.imem_gnt) begin
        pend      = 1'b1;
        pend_addr = gnt_addr;
        cnt       = rv_lat;
      end
      if (pend) begin
        cnt = cnt - 1;
        if (cnt <= 0) begin
          bus.imem_rvalid = 1'b1;
          bus.imem_rdata  = mem_word(pend_addr);
          pend            = 1'b0;
        end
      end
      bus.imem_gnt = bus.imem_req && gnt_en;
      gnt_addr     = bus.imem_addr;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    do begin
      step();
      n++;
    end while (!bus.imem_req && n < 20);
    chk(tag, 32'(bus.imem_req), 32'd1);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    do begin
      step();
      n++;
    end while (!bus.instr_valid && n < 20);
    chk(tag, 32'(bus.instr_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.instr_ready = 1'b1;
    bus.jump        = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    gnt_en          = 1'b1;
    rv_lat          = 1;

    repeat (3) step();
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    rst = 1'b0;
    step();
    chk("req_after_rst", 32'(bus.imem_req), 32'd1);

    for (int k = 0; k < 3; k++) begin
      if (k > 0) wait_req("seq_req");
      chk("seq_addr", bus.imem_addr, 32'(4 * k));
      t_req = cyc;
      if (k == 2) bus.instr_ready = 1'b0;
      wait_valid("seq_valid");
      chk("seq_latency", 32'(cyc - t_req), 32'd2);
      if (k > 0) chk("seq_thruput", 32'(cyc - t_val), 32'd3);
      t_val = cyc;
      chk("seq_ipc", bus.instr_pc, 32'(4 * k));
      chk("seq_instr", bus.instr, mem_word(32'(4 * k)));
    end

    chk("bp_opcode", 32'(bus.opcode), 32'h2B);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", 32'(bus.instr_valid), 32'd1);
      chk("bp_instr", bus.instr, 32'hAC00_0008);
      chk("bp_ipc", bus.instr_pc, 32'h8);
      chk("bp_noreq", 32'(bus.imem_req), 32'd0);
    end
    bus.instr_ready = 1'b1;
    wait_req("bp_req");
    chk("bp_next_addr", bus.imem_addr, 32'hC);

    wait_valid("c12_valid");
    chk("c12_ipc", bus.instr_pc, 32'hC);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0043;
    step();
    redirect_valid = 1'b0;
    chk("rdv_valid", 32'(bus.instr_valid), 32'd0);
    chk("rdv_req", 32'(bus.imem_req), 32'd1);
    chk("rdv_addr", bus.imem_addr, 32'h40);

    bus.jump = 1'b1;
    wait_valid("j_valid");
    chk("j_ipc", bus.instr_pc, 32'h40);
    chk("j_instr", bus.instr, 32'h0800_0010);
    chk("j_opcode", 32'(bus.opcode), 32'h02);
    wait_req("j_req");
    chk("j_addr", bus.imem_addr, 32'h40);
    bus.jump = 1'b0;

    wait_valid("j2_valid");
    chk("j2_ipc", bus.instr_pc, 32'h40);
    wait_req("s44_req");
    chk("s44_addr", bus.imem_addr, 32'h44);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    step();
    redirect_valid = 1'b0;
    chk("sqg_valid0", 32'(bus.instr_valid), 32'd0);
    chk("sqg_req0", 32'(bus.imem_req), 32'd0);
    step();
    chk("sqg_valid1", 32'(bus.instr_valid), 32'd0);
    chk("sqg_req1", 32'(bus.imem_req), 32'd1);
    chk("sqg_addr", bus.imem_addr, 32'h200);
    wait_valid("sqg_fetch");
    chk("sqg_ipc", bus.instr_pc, 32'h200);
    chk("sqg_instr", bus.instr, 32'hAC00_0200);
    rv_lat = 3;

    wait_req("w_req");
    chk("w_addr", bus.imem_addr, 32'h204);
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    step();
    redirect_valid = 1'b0;
    chk("sqw_valid0", 32'(bus.instr_valid), 32'd0);
    chk("sqw_req0", 32'(bus.imem_req), 32'd0);
    step();
    chk("sqw_valid1", 32'(bus.instr_valid), 32'd0);
    chk("sqw_req1", 32'(bus.imem_req), 32'd0);
    step();
    chk("sqw_valid2", 32'(bus.instr_valid), 32'd0);
    chk("sqw_req2", 32'(bus.imem_req), 32'd1);
    chk("sqw_addr", bus.imem_addr, 32'h100);
    rv_lat = 1;

    wait_valid("r100_valid");
    chk("r100_ipc", bus.instr_pc, 32'h100);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    step();
    redirect_valid = 1'b0;
    chk("top_addr", bus.imem_addr, 32'hFFFF_FFFC);
    wait_valid("top_valid");
    chk("top_ipc", bus.instr_pc, 32'hFFFF_FFFC);
    wait_req("wrap_req");
    chk("wrap_addr", bus.imem_addr, 32'h0);
    wait_valid("wrap_valid");
    chk("wrap_ipc", bus.instr_pc, 32'h0);
    rv_lat = 3;

    wait_req("mr_req");
    chk("mr_addr", bus.imem_addr, 32'h4);
    step();
    rst = 1'b1;
    step();
    chk("mr_valid", 32'(bus.instr_valid), 32'd0);
    chk("mr_req0", 32'(bus.imem_req), 32'd0);
    chk("mr_addr_rst", bus.imem_addr, 32'h0);
    rst    = 1'b0;
    rv_lat = 1;
    wait_req("mr_req1");
    chk("mr_addr1", bus.imem_addr, 32'h0);
    wait_valid("mr_fetch");
    chk("mr_ipc", bus.instr_pc, 32'h0);
    chk("mr_instr", bus.instr, 32'hAC00_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage for the single-issue MIPS core: owns the PC, fetches one 32-bit word at a time from instruction memory over a req/gnt/rvalid handshake and presents it, with its opcode field, to the decode/control stage over a valid/ready handshake. It sits upstream of the control unit. It consumes that unit's `jump` decision to form jump targets, and accepts an external redirect from execute for taken branches.

## Interface
- `ADDR_W`, 32: PC and memory address width (byte address).
- `RESET_PC`, 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `imem_req`  out  1  fetch request; high only in FETCH.
- `imem_addr`  out  ADDR_W  equals the `pc` register.
- `imem_gnt`  in  1  memory accepts the request this cycle.
- `imem_rvalid`  in  1  read data valid.
- `imem_rdata`  in  32  fetched instruction word.
- `instr_valid`  out  1  buffered instruction is available downstream.
- `instr`  out  32  buffered instruction.
- `opcode`  out  6  equals `instr[31:26]`; feeds the control unit.
- `instr_pc`  out  ADDR_W  PC of `instr`.
- `instr_ready`  in  1  decode accepts `instr` this cycle.
- `jump`  in  1  control-unit jump decode for the presented `opcode`.
- `redirect_valid`  in  1  taken branch from execute.
- `redirect_pc`  in  ADDR_W  branch target; bits [1:0] are ignored and forced to 0.

## Operation
- FSM states:
  - **FETCH**: `imem_req`=1. On `imem_gnt`, go to WAIT.
  - **WAIT**: waits for `imem_rvalid`. On `imem_rvalid`, capture `imem_rdata` into `instr` and `pc` into `instr_pc`, then go to VALID. If `squash` is set, discard the data, clear `squash` and go to FETCH.
  - **VALID**: `instr_valid`=1. On `instr_ready`, go to FETCH with the next PC.
- Next PC on a VALID handshake:
  - If `jump`=1: `{pc4[31:28], instr[25:0], 2'b00}`.
  - Otherwise: `pc4 = instr_pc + 4`.
  - Arithmetic is modulo 2^ADDR_W; 32'hFFFF_FFFC wraps to 0.
- Redirect has priority over everything else. In any state, `redirect_valid` loads `pc <= {redirect_pc[ADDR_W-1:2], 2'b00}`.
  - In FETCH without gnt: stay in FETCH. The next request uses the new PC.
  - In FETCH with gnt in the same cycle: go to WAIT with `squash`=1, because the in-flight response is stale.
  - In WAIT: set `squash`=1. If `imem_rvalid` arrives in the same cycle, discard the data and go straight to FETCH.
  - In VALID: drop the buffered instruction and go to FETCH. If `instr_ready` arrives in the same cycle, the handshake counts as complete, but the PC comes from the redirect, not from pc4 or the jump target.
- Ignored inputs:
  - `imem_rvalid` outside WAIT.
  - `jump` when `instr_valid`=0.
- At most one memory transaction is outstanding.

## Timing
- Reset values:
  - `state` = FETCH, `pc` = `RESET_PC`, `squash` = 0, `instr` = 0, `instr_pc` = 0.
  - `instr_valid` = 0 and `imem_req` = 0 while `rst` is high.
  - `imem_req` rises on the first cycle after `rst` falls.
- Reset mid-transaction: return to FETCH immediately and do not track the late `imem_rvalid`. The memory model must also be reset.
- Best-case latency, with gnt in the req cycle and rvalid one cycle later:
  - `instr_valid` is high 2 cycles after `imem_req` rose.
  - Throughput is 1 instruction per 3 cycles while `instr_ready` is held high.
- `instr`, `instr_pc` and `instr_valid` are registered and stable while `instr_valid`=1 and `instr_ready`=0.
- `imem_addr` is stable while `imem_req`=1 and `imem_gnt`=0, except after a redirect.

## Structure
- Shared package `mips_pkg`:
  - opcode constants (ALU_R 6'h00, JUMP 6'h02, BRANCH_EQ 6'h04, ADDI 6'h08, LOAD_WORD 6'h23, STORE_WORD 6'h2B);
  - fetch state encoding (FETCH, WAIT, VALID);
  - `PC_INC` = 4.
- Sub-module `fetch_pc_next`: combinational next-PC mux (redirect / jump / pc4). All registers stay in `instr_fetch_unit`.

## Test plan
- Reset then steady fetch, with gnt same cycle and rvalid +1 and ready held high → `imem_addr` 0, 4, 8; `instr_valid` high every third cycle; `instr_pc` matches.
- Backpressure: hold `instr_ready`=0 for 5 cycles at PC 8 → `instr` and `instr_pc` stable, no `imem_req`; release ready → next fetch at 12.
- Jump: instr 0x0800_0010 at PC 0x0000_0040 with `jump`=1 and ready=1 → next `imem_addr` = 0x0000_0040.
- Redirect during WAIT to 0x0000_0100, with rvalid 2 cycles later → data discarded, `instr_valid` stays 0, next request at 0x100.
- Simultaneous events:
  - redirect + gnt in FETCH → stale response squashed;
  - redirect + ready in VALID → next PC is `redirect_pc`, not pc4.
- Wrap and reset: PC 0xFFFF_FFFC advances to 0; asserting `rst` in WAIT → `instr_valid`=0, `imem_addr`=`RESET_PC`.
